// File: rtl/rgb_to_yuv_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rgb_to_yuv_encoder                                              |
// | Purpose  : Reads packed 24-bit RGB pixels from SRAM, converts them to      |
// |            BT.601 Y/U/V in fixed point, decimates U/V 2:1 horizontally     |
// |            and writes the Y, U and V planes back to SRAM.                  |
// | Ports    : CLOCK_50_I      - system clock                                  |
// |            resetn          - asynchronous active-low reset                 |
// |            enc_start       - start request (accepted only when idle)       |
// |            enc_done        - completion flag, held until next start        |
// |            SRAM_address    - registered SRAM word address                  |
// |            SRAM_write_data - registered SRAM write data                    |
// |            SRAM_we_n       - registered SRAM write enable, active low      |
// |            SRAM_read_data  - SRAM read data (READ_LAT cycles after addr)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rgb_to_yuv_encoder #(
  parameter int RGB_BASE = 146944,
  parameter int Y_BASE   = 0,
  parameter int U_BASE   = 38400,
  parameter int V_BASE   = 57600,
  parameter int PIXELS   = 76800,
  parameter int READ_LAT = 3
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        enc_start,
  output logic        enc_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  // Counter spans the read and wait phases continuously: 0..5+READ_LAT
  localparam int c_CW = $clog2(7 + READ_LAT);

  localparam logic [17:0]     c_RGB_BASE  = 18'(RGB_BASE);
  localparam logic [17:0]     c_Y_BASE    = 18'(Y_BASE);
  localparam logic [17:0]     c_U_BASE    = 18'(U_BASE);
  localparam logic [17:0]     c_V_BASE    = 18'(V_BASE);
  localparam logic [17:0]     c_G_LAST    = 18'(PIXELS / 4 - 1);
  localparam logic [c_CW-1:0] c_LAT       = c_CW'(READ_LAT);
  localparam logic [c_CW-1:0] c_RD_LAST   = c_CW'(5);
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(5 + READ_LAT);
  localparam logic [c_CW-1:0] c_PH_LAST   = c_CW'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_CONV = 3'd3,
    S_WR   = 3'd4
  } state_t;

  // Fixed-point conversion of one component: weighted sum, round, shift,
  // offset and saturate to 0..255.
  function automatic logic [7:0] f_conv(
    input logic signed [31:0] kr,
    input logic signed [31:0] kg,
    input logic signed [31:0] kb,
    input logic signed [31:0] off,
    input logic [7:0]         r,
    input logic [7:0]         g,
    input logic [7:0]         b
  );
    logic signed [31:0] s;
    s = kr * $signed({24'd0, r}) + kg * $signed({24'd0, g})
      + kb * $signed({24'd0, b}) + 32'sd32768;
    s = (s >>> 16) + off;
    if (s < 32'sd0)
      return 8'd0;
    else if (s > 32'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  state_t          r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [17:0]     r_g, w_g_nxt;
  logic [17:0]     r_rgb_ptr, w_rgb_ptr_nxt;
  logic [17:0]     w_addr_nxt;
  logic [15:0]     w_wdata_nxt;
  logic            w_we_n_nxt;
  logic            w_done_nxt;

  logic [15:0]     r_word [0:5];
  logic [7:0]      r_y    [0:3];
  logic [7:0]      r_u    [0:3];
  logic [7:0]      r_v    [0:3];
  logic [7:0]      r_ud   [0:1];
  logic [7:0]      r_vd   [0:1];

  logic [c_CW-1:0] w_cap_idx;
  logic            w_cap_en;
  logic [15:0]     w_wa, w_wb, w_wc;
  logic [8:0]      w_usum0, w_usum1, w_vsum0, w_vsum1;

  // ---------------------------------------------------------------------------
  // FSM state and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_g             <= '0;
      r_rgb_ptr       <= c_RGB_BASE;
      SRAM_address    <= c_RGB_BASE;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      enc_done        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_g             <= w_g_nxt;
      r_rgb_ptr       <= w_rgb_ptr_nxt;
      SRAM_address    <= w_addr_nxt;
      SRAM_write_data <= w_wdata_nxt;
      SRAM_we_n       <= w_we_n_nxt;
      enc_done        <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and next-output logic. Outputs are registered, so each
  // branch prepares the values seen during the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + c_CW'(1);
    w_g_nxt       = r_g;
    w_rgb_ptr_nxt = r_rgb_ptr;
    w_addr_nxt    = SRAM_address;
    w_wdata_nxt   = SRAM_write_data;
    w_we_n_nxt    = 1'b1;
    w_done_nxt    = enc_done;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (enc_start) begin
          w_done_nxt    = 1'b0;
          w_g_nxt       = '0;
          w_rgb_ptr_nxt = c_RGB_BASE;
          w_addr_nxt    = c_RGB_BASE;
          w_state_nxt   = S_RD;
        end
      end

      S_RD: begin
        if (r_cnt == c_RD_LAST)
          w_state_nxt = S_WAIT;
        else
          w_addr_nxt = SRAM_address + 18'd1;
      end

      S_WAIT: begin
        if (r_cnt == c_WAIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CONV;
        end
      end

      S_CONV: begin
        if (r_cnt == c_PH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WR;
          w_addr_nxt  = c_Y_BASE + {r_g[16:0], 1'b0};
          w_wdata_nxt = {r_y[0], r_y[1]};
          w_we_n_nxt  = 1'b0;
        end
      end

      S_WR: begin
        w_we_n_nxt = 1'b0;
        case (r_cnt)
          c_CW'(0): begin
            w_addr_nxt  = c_Y_BASE + {r_g[16:0], 1'b0} + 18'd1;
            w_wdata_nxt = {r_y[2], r_y[3]};
          end
          c_CW'(1): begin
            w_addr_nxt  = c_U_BASE + r_g;
            w_wdata_nxt = {r_ud[0], r_ud[1]};
          end
          c_CW'(2): begin
            w_addr_nxt  = c_V_BASE + r_g;
            w_wdata_nxt = {r_vd[0], r_vd[1]};
          end
          default: begin
            w_we_n_nxt = 1'b1;
            w_cnt_nxt  = '0;
            if (r_g == c_G_LAST) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_addr_nxt  = c_RGB_BASE;
            end else begin
              w_g_nxt       = r_g + 18'd1;
              w_rgb_ptr_nxt = r_rgb_ptr + 18'd6;
              w_addr_nxt    = r_rgb_ptr + 18'd6;
              w_state_nxt   = S_RD;
            end
          end
        endcase
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-data capture: word k arrives READ_LAT cycles after its address, so
  // it lands when the read/wait counter equals k + READ_LAT.
  // ---------------------------------------------------------------------------
  assign w_cap_idx = r_cnt - c_LAT;
  assign w_cap_en  = ((r_state == S_RD) || (r_state == S_WAIT)) && (r_cnt >= c_LAT);

  // Phase 0 converts p0/p1 from words 0..2, phase 1 converts p2/p3 from 3..5
  assign w_wa = (r_cnt == c_CW'(0)) ? r_word[0] : r_word[3];
  assign w_wb = (r_cnt == c_CW'(0)) ? r_word[1] : r_word[4];
  assign w_wc = (r_cnt == c_CW'(0)) ? r_word[2] : r_word[5];

  assign w_usum0 = {1'b0, r_u[0]} + {1'b0, r_u[1]} + 9'd1;
  assign w_usum1 = {1'b0, r_u[2]} + {1'b0, r_u[3]} + 9'd1;
  assign w_vsum0 = {1'b0, r_v[0]} + {1'b0, r_v[1]} + 9'd1;
  assign w_vsum1 = {1'b0, r_v[2]} + {1'b0, r_v[3]} + 9'd1;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 6; k++) r_word[k] <= 16'd0;
      for (int k = 0; k < 4; k++) begin
        r_y[k] <= 8'd0;
        r_u[k] <= 8'd0;
        r_v[k] <= 8'd0;
      end
      for (int k = 0; k < 2; k++) begin
        r_ud[k] <= 8'd0;
        r_vd[k] <= 8'd0;
      end
    end else begin
      if (w_cap_en) begin
        for (int k = 0; k < 6; k++)
          if (w_cap_idx == c_CW'(k)) r_word[k] <= SRAM_read_data;
      end

      if (r_state == S_CONV) begin
        if (r_cnt == c_CW'(0) || r_cnt == c_CW'(1)) begin
          // Even pixel: {R,G} in word a, B in high byte of word b.
          // Odd pixel : R in low byte of word b, {G,B} in word c.
          r_y[{r_cnt[0], 1'b0}] <= f_conv(32'sd16843, 32'sd33030, 32'sd6423, 32'sd16,
                                          w_wa[15:8], w_wa[7:0], w_wb[15:8]);
          r_u[{r_cnt[0], 1'b0}] <= f_conv(-32'sd9699, -32'sd19071, 32'sd28770, 32'sd128,
                                          w_wa[15:8], w_wa[7:0], w_wb[15:8]);
          r_v[{r_cnt[0], 1'b0}] <= f_conv(32'sd28770, -32'sd24117, -32'sd4653, 32'sd128,
                                          w_wa[15:8], w_wa[7:0], w_wb[15:8]);
          r_y[{r_cnt[0], 1'b1}] <= f_conv(32'sd16843, 32'sd33030, 32'sd6423, 32'sd16,
                                          w_wb[7:0], w_wc[15:8], w_wc[7:0]);
          r_u[{r_cnt[0], 1'b1}] <= f_conv(-32'sd9699, -32'sd19071, 32'sd28770, 32'sd128,
                                          w_wb[7:0], w_wc[15:8], w_wc[7:0]);
          r_v[{r_cnt[0], 1'b1}] <= f_conv(32'sd28770, -32'sd24117, -32'sd4653, 32'sd128,
                                          w_wb[7:0], w_wc[15:8], w_wc[7:0]);
        end else if (r_cnt == c_CW'(2)) begin
          // Rounded pair average; the 9-bit sum cannot overflow
          r_ud[0] <= w_usum0[8:1];
          r_ud[1] <= w_usum1[8:1];
          r_vd[0] <= w_vsum0[8:1];
          r_vd[1] <= w_vsum1[8:1];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_yuv_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rgb_to_yuv_encoder                                           |
// | Purpose  : Self-checking bench for rgb_to_yuv_encoder (PIXELS=8) with an   |
// |            SRAM read model and a behavioural colour-space reference.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rgb_to_yuv_encoder;

  localparam int RGB_BASE = 146944;
  localparam int Y_BASE   = 0;
  localparam int U_BASE   = 38400;
  localparam int V_BASE   = 57600;
  localparam int PIXELS   = 8;
  localparam int READ_LAT = 3;
  localparam int NW       = PIXELS / 4 * 6;
  localparam int NWR      = PIXELS;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn     = 1'b0;
  logic        enc_start  = 1'b0;
  logic        enc_done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data = 16'd0;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  rgb_to_yuv_encoder #(
    .RGB_BASE (RGB_BASE),
    .Y_BASE   (Y_BASE),
    .U_BASE   (U_BASE),
    .V_BASE   (V_BASE),
    .PIXELS   (PIXELS),
    .READ_LAT (READ_LAT)
  ) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .enc_start       (enc_start),
    .enc_done        (enc_done),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  // SRAM read model: three-stage delay from address to data
  logic [15:0] img [0:NW-1];
  logic [17:0] addr_s = '0;
  logic [15:0] d1 = 16'd0, d2 = 16'd0;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    int i;
    i = int'(a) - RGB_BASE;
    if (i >= 0 && i < NW) return img[i];
    return 16'hDEAD;
  endfunction

  always @(negedge CLOCK_50_I) addr_s = SRAM_address;
  always @(posedge CLOCK_50_I) begin
    d1             <= mem_rd(addr_s);
    d2             <= d1;
    SRAM_read_data <= d2;
  end

  // Write monitor
  typedef struct {
    int          cyc;
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t wlog[$];

  always @(negedge CLOCK_50_I) begin
    wr_t w;
    if (resetn === 1'b1 && SRAM_we_n === 1'b0) begin
      w.cyc = cyc;
      w.a   = SRAM_address;
      w.d   = SRAM_write_data;
      wlog.push_back(w);
    end
  end

  // Reference model: floor division by 2^16, offset, saturate
  function automatic int m_conv(input int kr, input int kg, input int kb,
                                input int off, input int r, input int g, input int b);
    int s, q;
    s = kr * r + kg * g + kb * b + 32768;
    q = s / 65536;
    if (s < 0 && q * 65536 != s) q = q - 1;
    q = q + off;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  int          exp_n [NWR];
  logic [17:0] exp_a [NWR];
  logic [15:0] exp_d [NWR];

  task automatic build_expected();
    int y [4];
    int u [4];
    int v [4];
    logic [15:0] w0, w1, w2;
    int r, g, b;
    for (int grp = 0; grp < PIXELS / 4; grp++) begin
      for (int p = 0; p < 4; p++) begin
        w0 = img[grp * 6 + (p / 2) * 3];
        w1 = img[grp * 6 + (p / 2) * 3 + 1];
        w2 = img[grp * 6 + (p / 2) * 3 + 2];
        if (p % 2 == 0) begin
          r = int'(w0[15:8]); g = int'(w0[7:0]); b = int'(w1[15:8]);
        end else begin
          r = int'(w1[7:0]);  g = int'(w2[15:8]); b = int'(w2[7:0]);
        end
        y[p] = m_conv(16843, 33030, 6423, 16, r, g, b);
        u[p] = m_conv(-9699, -19071, 28770, 128, r, g, b);
        v[p] = m_conv(28770, -24117, -4653, 128, r, g, b);
      end
      for (int j = 0; j < 4; j++) exp_n[grp * 4 + j] = 14 + 17 * grp + j;
      exp_a[grp * 4 + 0] = 18'(Y_BASE + 2 * grp);
      exp_a[grp * 4 + 1] = 18'(Y_BASE + 2 * grp + 1);
      exp_a[grp * 4 + 2] = 18'(U_BASE + grp);
      exp_a[grp * 4 + 3] = 18'(V_BASE + grp);
      exp_d[grp * 4 + 0] = {8'(y[0]), 8'(y[1])};
      exp_d[grp * 4 + 1] = {8'(y[2]), 8'(y[3])};
      exp_d[grp * 4 + 2] = {8'((u[0] + u[1] + 1) / 2), 8'((u[2] + u[3] + 1) / 2)};
      exp_d[grp * 4 + 3] = {8'((v[0] + v[1] + 1) / 2), 8'((v[2] + v[3] + 1) / 2)};
    end
  endtask

  // Pulse (or hold) enc_start, optionally re-pulse it at cycle busy_at, and
  // wait for enc_done within a fixed cycle budget (done_edge=-1 on timeout).
  task automatic run_encode(input int hold, input int busy_at, output int e0,
                            output int done_edge, output logic done_after_start);
    int n;
    wlog.delete();
    done_edge = -1;
    @(negedge CLOCK_50_I);
    enc_start = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    e0 = cyc;
    done_after_start = enc_done;
    repeat (hold - 1) @(posedge CLOCK_50_I);
    for (int k = 0; k < 400; k++) begin
      @(negedge CLOCK_50_I);
      n = cyc - e0 + 1;
      enc_start = (n == busy_at);
      if (enc_done === 1'b1) begin
        done_edge = cyc - e0;
        break;
      end
    end
    enc_start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    n_checks++;
    if (SRAM_address !== 18'(RGB_BASE)) $display("FAIL reset_addr got %h want %h", SRAM_address, 18'(RGB_BASE));
    else n_pass++;
    n_checks++;
    if (SRAM_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", SRAM_we_n);
    else n_pass++;
    n_checks++;
    if (SRAM_write_data !== 16'd0) $display("FAIL reset_wdata got %h want 0000", SRAM_write_data);
    else n_pass++;
    n_checks++;
    if (enc_done !== 1'b0) $display("FAIL reset_done got %b want 0", enc_done);
    else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
  endtask

  task automatic test_images();
    int e0, de;
    logic dn;
    logic [15:0] ly, lu, lv, lit;
    for (int pat = 0; pat < 6; pat++) begin
      for (int i = 0; i < NW; i++) begin
        case (pat)
          0:       img[i] = 16'h0000;
          1:       img[i] = 16'hFFFF;
          2:       img[i] = (i % 3 == 0) ? 16'hFF00 : 16'h0000;
          default: img[i] = 16'($urandom);
        endcase
      end
      case (pat)
        0:       begin ly = 16'h1010; lu = 16'h8080; lv = 16'h8080; end
        1:       begin ly = 16'hEBEB; lu = 16'h8080; lv = 16'h8080; end
        default: begin ly = 16'h5210; lu = 16'h6D6D; lv = 16'hB8B8; end
      endcase
      build_expected();
      run_encode(1, -1, e0, de, dn);
      n_checks++;
      if (de !== 34) $display("FAIL img%0d_done_edge got %0d want 34", pat, de);
      else n_pass++;
      n_checks++;
      if (wlog.size() !== NWR) $display("FAIL img%0d_write_count got %0d want %0d", pat, wlog.size(), NWR);
      else n_pass++;
      for (int i = 0; i < NWR && i < wlog.size(); i++) begin
        n_checks++;
        if (wlog[i].cyc - e0 + 1 !== exp_n[i] || wlog[i].a !== exp_a[i] || wlog[i].d !== exp_d[i])
          $display("FAIL img%0d_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                   pat, i, wlog[i].cyc - e0 + 1, wlog[i].a, wlog[i].d, exp_n[i], exp_a[i], exp_d[i]);
        else n_pass++;
        if (pat < 3) begin
          lit = (i % 4 < 2) ? ly : ((i % 4 == 2) ? lu : lv);
          n_checks++;
          if (wlog[i].d !== lit) $display("FAIL img%0d_literal%0d got %h want %h", pat, i, wlog[i].d, lit);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_timing();
    int e0, de;
    logic dn;
    int want [NWR];
    want[0] = 14; want[1] = 15; want[2] = 16; want[3] = 17;
    want[4] = 31; want[5] = 32; want[6] = 33; want[7] = 34;
    for (int i = 0; i < NW; i++) img[i] = 16'($urandom);
    run_encode(1, -1, e0, de, dn);
    n_checks++;
    if (dn !== 1'b0) $display("FAIL timing_done_cleared got %b want 0", dn);
    else n_pass++;
    n_checks++;
    if (de !== 34) $display("FAIL timing_done_edge got %0d want 34", de);
    else n_pass++;
    for (int i = 0; i < NWR && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].cyc - e0 + 1 !== want[i])
        $display("FAIL timing_write%0d got cycle %0d want %0d", i, wlog[i].cyc - e0 + 1, want[i]);
      else n_pass++;
    end
    repeat (10) @(negedge CLOCK_50_I);
    n_checks++;
    if (enc_done !== 1'b1) $display("FAIL timing_done_held got %b want 1", enc_done);
    else n_pass++;
    n_checks++;
    if (wlog.size() !== NWR) $display("FAIL timing_write_count got %0d want %0d", wlog.size(), NWR);
    else n_pass++;
  endtask

  task automatic test_busy_restart();
    int e0, de;
    logic dn;
    for (int i = 0; i < NW; i++) img[i] = 16'($urandom);
    build_expected();
    for (int run = 0; run < 2; run++) begin
      // run 0: extra start pulse in S_RD of group 1; run 1: start held 2 cycles
      if (run == 0) run_encode(1, 20, e0, de, dn);
      else          run_encode(2, -1, e0, de, dn);
      n_checks++;
      if (dn !== 1'b0) $display("FAIL busy%0d_done_cleared got %b want 0", run, dn);
      else n_pass++;
      n_checks++;
      if (de !== 34 || wlog.size() !== NWR)
        $display("FAIL busy%0d_done_and_count got edge %0d writes %0d want edge 34 writes %0d",
                 run, de, wlog.size(), NWR);
      else n_pass++;
      for (int i = 0; i < NWR && i < wlog.size(); i++) begin
        n_checks++;
        if (wlog[i].cyc - e0 + 1 !== exp_n[i] || wlog[i].a !== exp_a[i] || wlog[i].d !== exp_d[i])
          $display("FAIL busy%0d_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                   run, i, wlog[i].cyc - e0 + 1, wlog[i].a, wlog[i].d, exp_n[i], exp_a[i], exp_d[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midway();
    int e0, de;
    logic dn;
    for (int i = 0; i < NW; i++) img[i] = 16'($urandom);
    build_expected();
    @(negedge CLOCK_50_I);
    enc_start = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    e0 = cyc;
    @(negedge CLOCK_50_I);
    enc_start = 1'b0;
    repeat (14) @(negedge CLOCK_50_I);  // negedge of cycle 15 (second write)
    n_checks++;
    if (SRAM_we_n !== 1'b0 || SRAM_address !== exp_a[1])
      $display("FAIL midrst_in_write got we_n %b addr %0d want we_n 0 addr %0d", SRAM_we_n, SRAM_address, exp_a[1]);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (SRAM_address !== 18'(RGB_BASE) || SRAM_we_n !== 1'b1 || SRAM_write_data !== 16'd0 || enc_done !== 1'b0)
      $display("FAIL midrst_async got addr %0d we_n %b data %h done %b want %0d 1 0000 0",
               SRAM_address, SRAM_we_n, SRAM_write_data, enc_done, RGB_BASE);
    else n_pass++;
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    wlog.delete();
    repeat (40) @(negedge CLOCK_50_I);
    n_checks++;
    if (wlog.size() !== 0 || enc_done !== 1'b0)
      $display("FAIL midrst_quiet got writes %0d done %b want 0 0", wlog.size(), enc_done);
    else n_pass++;
    run_encode(1, -1, e0, de, dn);
    n_checks++;
    if (de !== 34 || wlog.size() !== NWR)
      $display("FAIL midrst_restart got edge %0d writes %0d want 34 %0d", de, wlog.size(), NWR);
    else n_pass++;
    for (int i = 0; i < NWR && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i].cyc - e0 + 1 !== exp_n[i] || wlog[i].a !== exp_a[i] || wlog[i].d !== exp_d[i])
        $display("FAIL midrst_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                 i, wlog[i].cyc - e0 + 1, wlog[i].a, wlog[i].d, exp_n[i], exp_a[i], exp_d[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) img[i] = 16'd0;
    test_reset();
    test_images();
    test_timing();
    test_busy_restart();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
